// File: rtl/psw_ctrl_pkg.sv
// Shared definitions for the PSW write controller: bit positions, FSM states,
// requester identifiers and the J/K pulse helper.
package psw_ctrl_pkg;

    localparam int PSW_W   = 16;
    localparam int C_BIT   = 0;
    localparam int V_BIT   = 1;
    localparam int Z_BIT   = 2;
    localparam int N_BIT   = 3;
    localparam int IE_BIT_DEF = 4;
    localparam logic [PSW_W-1:0] RO_MASK_DEF = 16'h0000;
    localparam int NUM_REQ = 4;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DRIVE    = 2'd1,
        ST_IRQ_SAVE = 2'd2,
        ST_IRQ_MASK = 2'd3
    } state_t;

    // Index order is also priority order: lower index wins.
    typedef enum logic [1:0] {
        REQ_IRQ = 2'd0,
        REQ_RTI = 2'd1,
        REQ_SW  = 2'd2,
        REQ_ALU = 2'd3
    } req_id_t;

    typedef struct packed {
        logic [PSW_W-1:0] j;
        logic [PSW_W-1:0] k;
    } jk_t;

    // Drive each enabled bit towards its value in val; J and K are disjoint by construction.
    function automatic jk_t jk_load(input logic [PSW_W-1:0] val, input logic [PSW_W-1:0] en);
        jk_t res;
        res.j = val & en;
        res.k = ~val & en;
        return res;
    endfunction

endpackage

// File: rtl/psw_ctrl_arb.sv
// Fixed-priority grant generator; grants only while the controller is idle.
module psw_ctrl_arb
    import psw_ctrl_pkg::*;
(
    input  logic               en,
    input  logic [NUM_REQ-1:0] vld,
    output logic [NUM_REQ-1:0] gnt
);

    // One-hot grant to the lowest-index valid requester.
    always_comb begin
        gnt = 4'b0000;
        if (en) begin
            if (vld[REQ_IRQ]) begin
                gnt[REQ_IRQ] = 1'b1;
            end else if (vld[REQ_RTI]) begin
                gnt[REQ_RTI] = 1'b1;
            end else if (vld[REQ_SW]) begin
                gnt[REQ_SW] = 1'b1;
            end else if (vld[REQ_ALU]) begin
                gnt[REQ_ALU] = 1'b1;
            end else begin
                gnt = 4'b0000;
            end
        end else begin
            gnt = 4'b0000;
        end
    end

endmodule

// File: rtl/psw_ctrl.sv
// PSW write sequencer: arbitrates flag/SW/RTI/IRQ writers and turns each grant
// into one-cycle J/K pulses for the JK-flop PSW bank.
module psw_ctrl
    import psw_ctrl_pkg::*;
#(
    parameter int          IE_BIT  = IE_BIT_DEF,
    parameter logic [15:0] RO_MASK = RO_MASK_DEF,
    parameter int          FLAG_W  = 4
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic [15:0]       psw_q,
    input  logic              irq_vld,
    output logic              irq_rdy,
    input  logic              rti_vld,
    input  logic [15:0]       rti_word,
    output logic              rti_rdy,
    input  logic              sw_vld,
    input  logic              sw_set,
    input  logic [15:0]       sw_mask,
    output logic              sw_rdy,
    input  logic              alu_vld,
    input  logic [FLAG_W-1:0] alu_mask,
    input  logic [FLAG_W-1:0] alu_flags,
    output logic              alu_rdy,
    output logic [15:0]       j,
    output logic [15:0]       k,
    output logic [15:0]       saved_psw,
    output logic              saved_vld,
    output logic              busy
);

    localparam logic [15:0] IE_ONEHOT = 16'h0001 << IE_BIT;

    state_t             state_r;
    state_t             next_state_s;
    logic [15:0]        j_r;
    logic [15:0]        k_r;
    logic [15:0]        saved_psw_r;
    logic               saved_vld_r;
    logic [NUM_REQ-1:0] vld_s;
    logic [NUM_REQ-1:0] gnt_s;
    jk_t                grant_jk_s;
    jk_t                next_jk_s;
    logic               next_save_s;

    assign vld_s[REQ_IRQ] = irq_vld;
    assign vld_s[REQ_RTI] = rti_vld;
    assign vld_s[REQ_SW]  = sw_vld;
    assign vld_s[REQ_ALU] = alu_vld;

    psw_ctrl_arb u_arb (
        .en  (state_r == ST_IDLE),
        .vld (vld_s),
        .gnt (gnt_s)
    );

    assign irq_rdy = gnt_s[REQ_IRQ];
    assign rti_rdy = gnt_s[REQ_RTI];
    assign sw_rdy  = gnt_s[REQ_SW];
    assign alu_rdy = gnt_s[REQ_ALU];

    // J/K image for a generic (non-IRQ) grant; read-only bits are protected for SW and RTI only.
    always_comb begin
        grant_jk_s = '0;
        if (gnt_s[REQ_RTI]) begin
            grant_jk_s = jk_load(rti_word, ~RO_MASK);
        end else if (gnt_s[REQ_SW]) begin
            grant_jk_s = jk_load(sw_set ? 16'hFFFF : 16'h0000, sw_mask & ~RO_MASK);
        end else if (gnt_s[REQ_ALU]) begin
            grant_jk_s = jk_load({{(16-FLAG_W){1'b0}}, alu_flags},
                                 {{(16-FLAG_W){1'b0}}, alu_mask});
        end else begin
            grant_jk_s = '0;
        end
    end

    // Next-state and next-pulse decode.
    always_comb begin
        next_state_s = state_r;
        next_jk_s    = '0;
        next_save_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (gnt_s[REQ_IRQ]) begin
                    next_state_s = ST_IRQ_SAVE;
                    next_save_s  = 1'b1;
                end else if (|gnt_s) begin
                    next_state_s = ST_DRIVE;
                    next_jk_s    = grant_jk_s;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_DRIVE: begin
                next_state_s = ST_IDLE;
            end
            ST_IRQ_SAVE: begin
                // IE is cleared unconditionally, even if it is already 0.
                next_state_s = ST_IRQ_MASK;
                next_jk_s.k  = IE_ONEHOT;
            end
            ST_IRQ_MASK: begin
                next_state_s = ST_IDLE;
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // State, pulse and snapshot registers; the snapshot is taken on the IRQ grant edge.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r     <= ST_IDLE;
            j_r         <= 16'h0000;
            k_r         <= 16'h0000;
            saved_psw_r <= 16'h0000;
            saved_vld_r <= 1'b0;
        end else begin
            state_r     <= next_state_s;
            j_r         <= next_jk_s.j;
            k_r         <= next_jk_s.k;
            saved_vld_r <= next_save_s;
            if (next_save_s) begin
                saved_psw_r <= psw_q;
            end else begin
                saved_psw_r <= saved_psw_r;
            end
        end
    end

    assign j         = j_r;
    assign k         = k_r;
    assign saved_psw = saved_psw_r;
    assign saved_vld = saved_vld_r;
    assign busy      = (state_r != ST_IDLE);

endmodule
